// File: rtl/game_flow_pkg.sv
// Shared types and constants for the rhythm-game flow controller.
// Screen-select vector layout and the state encoding live here so the bench-facing top stays small.
package game_flow_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      PAUSE = 3'd2,
      WIN   = 3'd3,
      LOSE  = 3'd4
   } state_t;

   localparam int MAX_MISS_DEF = 7;

   localparam int SEL_W     = 5;
   localparam int SEL_IFACE = 0;
   localparam int SEL_MAP   = 1;
   localparam int SEL_PAUSE = 2;
   localparam int SEL_WIN   = 3;
   localparam int SEL_LOSE  = 4;

   // PAUSE keeps the play field visible underneath the overlay.
   function automatic logic [SEL_W-1:0] screen_sel(input state_t s);
      logic [SEL_W-1:0] sel;
      sel = '0;
      case (s)
         IDLE:    sel[SEL_IFACE] = 1'b1;
         PLAY:    sel[SEL_MAP]   = 1'b1;
         PAUSE: begin
            sel[SEL_MAP]   = 1'b1;
            sel[SEL_PAUSE] = 1'b1;
         end
         WIN:     sel[SEL_WIN]   = 1'b1;
         LOSE:    sel[SEL_LOSE]  = 1'b1;
         default: sel[SEL_IFACE] = 1'b1;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Key/judge inputs and screen/score outputs of the game-flow controller.
// master drives keys and judge levels; slave is the controller itself.
interface game_flow_ctrl_if #(
   parameter int MISS_W = 3,
   parameter int HIT_W  = 8
);
   logic              key_start;
   logic              key_back;
   logic              key_pause;
   logic              miss;
   logic              hit;
   logic              done;
   logic              interface_en;
   logic              map_en;
   logic              paused;
   logic              win;
   logic              lose;
   logic [MISS_W-1:0] total_miss;
   logic [HIT_W-1:0]  hits;

   modport master (
      output key_start, key_back, key_pause, miss, hit, done,
      input  interface_en, map_en, paused, win, lose, total_miss, hits
   );

   modport slave (
      input  key_start, key_back, key_pause, miss, hit, done,
      output interface_en, map_en, paused, win, lose, total_miss, hits
   );
endinterface

// File: rtl/game_flow_ctrl_rise_pulse.sv
// One-bit rising-edge detector: pulse is high while d is high and was low last cycle.
module rise_pulse (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic pulse
);
   logic d_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) d_q <= 1'b0;
      else       d_q <= d;
   end

   assign pulse = d & ~d_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: title / play / pause / win / lose sequencing with miss budget and hit count.
//   state | meaning
//   IDLE  | title screen, counters cleared
//   PLAY  | song running, counting misses and hits
//   PAUSE | play field frozen under pause overlay
//   WIN   | song finished within miss budget, counters held
//   LOSE  | miss budget exhausted, counters held
module game_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter int MAX_MISS = MAX_MISS_DEF,
   parameter int MISS_W   = 3,
   parameter int HIT_W    = 8
) (
   input logic             clk,
   input logic             reset,
   game_flow_ctrl_if.slave bus
);
   localparam logic [MISS_W-1:0] MAX_MISS_V = MISS_W'(MAX_MISS);

   logic ev_start, ev_back, ev_pause, ev_miss, ev_hit;

   rise_pulse u_rp_start (.clk(clk), .reset(reset), .d(bus.key_start), .pulse(ev_start));
   rise_pulse u_rp_back  (.clk(clk), .reset(reset), .d(bus.key_back),  .pulse(ev_back));
   rise_pulse u_rp_pause (.clk(clk), .reset(reset), .d(bus.key_pause), .pulse(ev_pause));
   rise_pulse u_rp_miss  (.clk(clk), .reset(reset), .d(bus.miss),      .pulse(ev_miss));
   rise_pulse u_rp_hit   (.clk(clk), .reset(reset), .d(bus.hit),       .pulse(ev_hit));

   state_t            state, state_nx;
   logic [SEL_W-1:0]  sel_q;
   logic [MISS_W-1:0] miss_q, miss_nx, miss_inc;
   logic [HIT_W-1:0]  hits_q, hits_nx, hits_inc;

   assign miss_inc = miss_q + MISS_W'(1);
   assign hits_inc = (hits_q == '1) ? hits_q : hits_q + HIT_W'(1);

   always_comb begin
      state_nx = state;
      miss_nx  = miss_q;
      hits_nx  = hits_q;
      case (state)
         IDLE: begin
            miss_nx = '0;
            hits_nx = '0;
            if (ev_start) state_nx = PLAY;
         end
         PLAY: begin
            if (ev_back) begin
               state_nx = IDLE;
               miss_nx  = '0;
               hits_nx  = '0;
            end else if (bus.done) begin
               state_nx = WIN;
            end else if (ev_pause) begin
               state_nx = PAUSE;
            end else begin
               if (ev_hit) hits_nx = hits_inc;
               if (ev_miss) begin
                  miss_nx = miss_inc;
                  if (miss_inc == MAX_MISS_V) state_nx = LOSE;
               end
            end
         end
         PAUSE: begin
            if (ev_back) begin
               state_nx = IDLE;
               miss_nx  = '0;
               hits_nx  = '0;
            end else if (ev_pause) begin
               state_nx = PLAY;
            end
         end
         WIN, LOSE: begin
            if (ev_back) begin
               state_nx = IDLE;
               miss_nx  = '0;
               hits_nx  = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            miss_nx  = '0;
            hits_nx  = '0;
         end
      endcase
   end

   // Screen selects are registered from the next state so they change with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         sel_q  <= screen_sel(IDLE);
         miss_q <= '0;
         hits_q <= '0;
      end else begin
         state  <= state_nx;
         sel_q  <= screen_sel(state_nx);
         miss_q <= miss_nx;
         hits_q <= hits_nx;
      end
   end

   assign bus.interface_en = sel_q[SEL_IFACE];
   assign bus.map_en       = sel_q[SEL_MAP];
   assign bus.paused       = sel_q[SEL_PAUSE];
   assign bus.win          = sel_q[SEL_WIN];
   assign bus.lose         = sel_q[SEL_LOSE];
   assign bus.total_miss   = miss_q;
   assign bus.hits         = hits_q;
endmodule
